layer_result_writer: RTL and testbench

- Write-side counterpart of the layer BRAM read path. Captures one 64-bit signed layer result, defined as 8 lanes of 8 bits, when the layer raises done. Serializes the lanes into a true-dual-port output BRAM, one byte per cycle.
- Sits after the last layer's processing unit. Fills rows of an output buffer that the next layer or host later reads back through the same address/enable port style.

---
 rtl/layer_pkg.sv | 19 +
 rtl/layer_result_writer.sv | 127 ++++++++++++
 tb/tb_layer_result_writer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/layer_pkg.sv
// layer_pkg: shared lane defaults, writer FSM states and BRAM address helper
package layer_pkg;

    localparam int DEF_LANE_WIDTH = 8;
    localparam int DEF_LANE_NUM   = 8;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    // Flat BRAM address of one lane of one stored result
    function automatic int unsigned lane_addr(
        input int unsigned base,
        input int unsigned row,
        input int unsigned lane,
        input int unsigned lane_num
    );
        return base + row * lane_num + lane;
    endfunction

endpackage

// File: rtl/layer_result_writer.sv
// layer_result_writer: serializes captured layer results into an output BRAM, one lane per cycle
module layer_result_writer
    import layer_pkg::*;
#(
    parameter int LANE_WIDTH = DEF_LANE_WIDTH,
    parameter int LANE_NUM   = DEF_LANE_NUM,
    parameter int ROWS       = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int BASE_ADDR  = 0
)(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic                           valid_i,
    input  logic [LANE_WIDTH*LANE_NUM-1:0] result_i,
    output logic                           ready_o,
    output logic                           wr_en_o,
    output logic                           wr_we_o,
    output logic [ADDR_WIDTH-1:0]          wr_addr_o,
    output logic [LANE_WIDTH-1:0]          wr_data_o,
    output logic                           done_o,
    output logic                           wrapped_o,
    output logic                           overflow_o
);

    localparam int RES_W  = LANE_WIDTH * LANE_NUM;
    localparam int ROW_W  = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int LANE_W = LANE_NUM > 1 ? $clog2(LANE_NUM) : 1;

    state_t                  state;
    logic [ROW_W-1:0]        row;
    logic [LANE_W-1:0]       lane;
    logic [RES_W-1:0]        shreg;
    logic [RES_W-1:0]        pend_data;
    logic                    pending;
    logic                    clr_seen;
    logic [ROW_W-1:0]        row_eff;
    logic                    load;
    logic [RES_W-1:0]        load_data;
    logic [ADDR_WIDTH-1:0]   start_addr;

    assign ready_o    = ~pending;
    // A clear coincident with a capture already steers the new result to row 0
    assign row_eff    = clear_i ? '0 : row;
    assign load       = (state == IDLE && valid_i) || (state == DONE && (pending || valid_i));
    assign load_data  = pending ? pend_data : result_i;
    assign start_addr = ADDR_WIDTH'(lane_addr(BASE_ADDR, 32'(row_eff), 0, LANE_NUM));

    // Writer FSM: capture, lane-by-lane BRAM writes, row bookkeeping and sticky flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            row        <= '0;
            lane       <= '0;
            shreg      <= '0;
            pend_data  <= '0;
            pending    <= 1'b0;
            clr_seen   <= 1'b0;
            wr_en_o    <= 1'b0;
            wr_we_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            done_o     <= 1'b0;
            wrapped_o  <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (clear_i) begin
                row        <= '0;
                wrapped_o  <= 1'b0;
                overflow_o <= 1'b0;
            end
            case (state)
                WRITE: begin
                    if (clear_i)
                        clr_seen <= 1'b1;
                    if (valid_i && pending)
                        overflow_o <= 1'b1;
                    else if (valid_i) begin
                        pending   <= 1'b1;
                        pend_data <= result_i;
                    end
                    if (lane == LANE_W'(LANE_NUM - 1)) begin
                        state    <= DONE;
                        wr_en_o  <= 1'b0;
                        wr_we_o  <= 1'b0;
                        done_o   <= 1'b1;
                        clr_seen <= 1'b0;
                        // A clear seen during this result wins over the normal advance
                        if (clear_i || clr_seen)
                            row <= '0;
                        else if (row == ROW_W'(ROWS - 1)) begin
                            row       <= '0;
                            wrapped_o <= 1'b1;
                        end else
                            row <= row + 1'b1;
                    end else begin
                        lane      <= lane + 1'b1;
                        wr_addr_o <= wr_addr_o + 1'b1;
                        wr_data_o <= shreg[LANE_WIDTH-1:0];
                        shreg     <= shreg >> LANE_WIDTH;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (pending) begin
                        pending <= 1'b0;
                        if (valid_i)
                            overflow_o <= 1'b1;
                    end
                end
                IDLE: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (load) begin
                state     <= WRITE;
                lane      <= '0;
                wr_en_o   <= 1'b1;
                wr_we_o   <= 1'b1;
                wr_addr_o <= start_addr;
                wr_data_o <= load_data[LANE_WIDTH-1:0];
                shreg     <= load_data >> LANE_WIDTH;
            end
        end
    end

endmodule

// File: tb/tb_layer_result_writer.sv
// tb_layer_result_writer: scoreboard bench for the layer result BRAM writer
module tb_layer_result_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        valid = 1'b0;
    logic [63:0] result = '0;
    logic        ready, wr_en, wr_we, done, wrapped, overflow;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done = 0;
    int prev_done = 0;
    int ready_low = 0;
    int t0 = 0;
    logic done_wrapped = 1'b0;
    int mrow = 0;
    logic [13:0] sb[$];

    layer_result_writer dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(valid), .result_i(result),
        .ready_o(ready), .wr_en_o(wr_en), .wr_we_o(wr_we), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .done_o(done), .wrapped_o(wrapped), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected BRAM traffic for one accepted result at the model's current row
    task automatic expect_result(input logic [63:0] d);
        for (int k = 0; k < 8; k++) begin
            logic [5:0] a;
            a = 6'(mrow * 8 + k);
            sb.push_back({a, d[8*k +: 8]});
        end
        mrow = (mrow + 1) % 8;
    endtask

    // Advance one cycle and score any BRAM write or done pulse seen on the port
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!ready) ready_low++;
        chk("en_eq_we", wr_en, wr_we);
        if (wr_we) begin
            chk("write_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                logic [13:0] e;
                e = sb.pop_front();
                chk("wr_addr", wr_addr, e[13:8]);
                chk("wr_data", wr_data, e[7:0]);
            end
        end
        if (done) begin
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
            done_wrapped = wrapped;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [63:0] d);
        valid = 1'b1;
        result = d;
        tick();
        valid = 1'b0;
    endtask

    task automatic do_reset();
        sb.delete();
        rst = 1'b1;
        valid = 1'b0;
        clear = 1'b0;
        ticks(2);
        rst = 1'b0;
        mrow = 0;
        done_cnt = 0;
        ready_low = 0;
    endtask

    initial begin
        logic [63:0] d;
        do_reset();
        chk("rst_ready", ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_we", wr_we, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_done", done, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_overflow", overflow, 0);

        // Single result: lane order, latency, ready stays high
        t0 = cyc;
        expect_result(64'h8877665544332211);
        pulse(64'h8877665544332211);
        ticks(11);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_lat", last_done - t0, 9);
        chk("t1_ready_low", ready_low, 0);
        chk("t1_sb_empty", sb.size(), 0);

        // Two results three cycles apart: second is buffered and follows immediately
        do_reset();
        expect_result(64'h0807060504030201);
        pulse(64'h0807060504030201);
        ticks(2);
        expect_result(64'h1817161514131211);
        pulse(64'h1817161514131211);
        chk("t2_ready_after_b", ready, 0);
        ticks(20);
        chk("t2_done_cnt", done_cnt, 2);
        chk("t2_b_follows_a", last_done - prev_done, 9);
        chk("t2_overflow", overflow, 0);
        chk("t2_ready_end", ready, 1);
        chk("t2_sb_empty", sb.size(), 0);

        // Three consecutive pulses: the third is dropped
        do_reset();
        expect_result(64'hA1A2A3A4A5A6A7A8);
        pulse(64'hA1A2A3A4A5A6A7A8);
        expect_result(64'hB1B2B3B4B5B6B7B8);
        pulse(64'hB1B2B3B4B5B6B7B8);
        pulse(64'hC1C2C3C4C5C6C7C8);
        chk("t3_overflow_now", overflow, 1);
        ticks(25);
        chk("t3_done_cnt", done_cnt, 2);
        chk("t3_overflow", overflow, 1);
        chk("t3_sb_empty", sb.size(), 0);

        // Nine results: row pointer wraps at the eighth done
        do_reset();
        for (int i = 0; i < 9; i++) begin
            d = {$urandom, $urandom};
            expect_result(d);
            pulse(d);
            ticks(10);
            chk("t4_wrap_at_done", done_wrapped, i >= 7);
            chk("t4_wrapped", wrapped, i >= 7);
        end
        chk("t4_done_cnt", done_cnt, 9);
        chk("t4_sb_empty", sb.size(), 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t4_clear_wrapped", wrapped, 0);

        // Clear during lane 3 of row 2: row 2 completes, next result goes to row 0
        do_reset();
        expect_result(64'h1111111111111111);
        pulse(64'h1111111111111111);
        expect_result(64'h2222222222222222);
        pulse(64'h2222222222222222);
        pulse(64'h3333333333333333);
        ticks(25);
        chk("t5_overflow_set", overflow, 1);
        expect_result(64'hF7E6D5C4B3A29180);
        pulse(64'hF7E6D5C4B3A29180);
        ticks(3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mrow = 0;
        chk("t5_overflow_clr", overflow, 0);
        ticks(10);
        chk("t5_done_cnt", done_cnt, 3);
        expect_result(64'h0123456789ABCDEF);
        pulse(64'h0123456789ABCDEF);
        ticks(10);
        chk("t5_done_cnt2", done_cnt, 4);
        chk("t5_wrapped", wrapped, 0);
        chk("t5_overflow", overflow, 0);
        chk("t5_sb_empty", sb.size(), 0);

        // Reset during lane 4 with a pending result aborts everything
        do_reset();
        expect_result(64'h5A5A5A5A5A5A5A5A);
        pulse(64'h5A5A5A5A5A5A5A5A);
        expect_result(64'hA5A5A5A5A5A5A5A5);
        pulse(64'hA5A5A5A5A5A5A5A5);
        ticks(3);
        chk("t6_lane4_addr", wr_addr, 4);
        sb.delete();
        rst = 1'b1;
        tick();
        chk("t6_we_after_rst", wr_we, 0);
        chk("t6_done_after_rst", done, 0);
        rst = 1'b0;
        mrow = 0;
        done_cnt = 0;
        ticks(15);
        chk("t6_no_done", done_cnt, 0);
        chk("t6_ready", ready, 1);
        expect_result(64'hDEADBEEFCAFEF00D);
        pulse(64'hDEADBEEFCAFEF00D);
        ticks(10);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
